cache_fill_ctrl: RTL and testbench

- Miss handler sitting directly upstream of the direct-mapped cache (128 blocks x 8 words, 16-bit words, 16-byte blocks).
- On a cache miss, it fetches the whole 8-word block from the pipelined main memory and writes each returned word into the cache data array.
- After the last word it writes the tag, then releases the pipeline stall.
- One instance each serves the I-cache and the D-cache.

---
 rtl/cache_fill_ctrl.sv | 117 +++++++++++
 tb/tb_cache_fill_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: streams an 8-word block from pipelined memory into the
// cache data array, then writes the tag and drops the pipeline stall.
module cache_fill_ctrl #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int ADDR_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] cache_address,
   output logic [15:0]       cache_data,
   output logic              fill_done
);

   localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);
   localparam logic [CNT_W-1:0]  N_WORDS  = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] TAG  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rcv_cnt;
   logic              rst_dly;
   logic              req_act;
   logic              rcv_act;
   logic              quiet;
   logic [ADDR_W-1:0] req_off;
   logic [ADDR_W-1:0] rcv_off;

   assign req_act = (state == FILL) && (req_cnt < N_WORDS);
   assign rcv_act = (state == FILL) && memory_data_valid && (rcv_cnt < N_WORDS);
   assign req_off = ADDR_W'({req_cnt, 1'b0});
   assign rcv_off = ADDR_W'({rcv_cnt, 1'b0});
   // Outputs stay silent during reset and for one cycle after release.
   assign quiet   = rst || rst_dly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         base    <= '0;
         req_cnt <= '0;
         rcv_cnt <= '0;
         rst_dly <= 1'b1;
      end else begin
         rst_dly <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_detected && !rst_dly) begin
                  state   <= FILL;
                  base    <= miss_address & ~OFF_MASK;
                  req_cnt <= '0;
                  rcv_cnt <= '0;
               end
            end
            FILL: begin
               if (req_act) req_cnt <= req_cnt + 1'b1;
               if (rcv_act) begin
                  rcv_cnt <= rcv_cnt + 1'b1;
                  if (rcv_cnt == LAST) state <= TAG;
               end
            end
            TAG:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      fsm_busy         = 1'b0;
      mem_read_en      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      cache_address    = '0;
      cache_data       = '0;
      fill_done        = 1'b0;
      if (!quiet) begin
         case (state)
            IDLE: fsm_busy = miss_detected;
            FILL: begin
               fsm_busy      = 1'b1;
               cache_address = base;
               if (req_act) begin
                  mem_read_en    = 1'b1;
                  memory_address = base + req_off;
               end
               if (rcv_act) begin
                  write_data_array = 1'b1;
                  cache_address    = base + rcv_off;
                  cache_data       = memory_data;
               end
            end
            TAG: begin
               fsm_busy        = 1'b1;
               write_tag_array = 1'b1;
               fill_done       = 1'b1;
               cache_address   = base;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: timeline model of each fill, per-cycle
// compare process, and a small cache/tag model fed by the DUT's writes.
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_done;
   logic [15:0] memory_address, cache_address, cache_data;

   cache_fill_ctrl #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst),
      .miss_detected(miss_detected), .miss_address(miss_address),
      .memory_data_valid(memory_data_valid), .memory_data(memory_data),
      .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
      .write_data_array(write_data_array), .write_tag_array(write_tag_array),
      .cache_address(cache_address), .cache_data(cache_data), .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Expected outputs for the current cycle, set by the stimulus.
   logic        e_busy, e_rd, e_wd, e_tag, e_chk_maddr, e_chk_cdata;
   logic [15:0] e_maddr, e_caddr, e_cdata;
   logic        chk_en = 1'b0;

   // Cache model: 128 blocks x 8 words, tag = addr[15:11], index = addr[10:4].
   logic [15:0] mdata [0:1023];
   logic [4:0]  mtag  [0:127];
   logic        mvalid[0:127];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return a ^ 16'h5555;
   endfunction

   task automatic exp_idle(input logic busy);
      e_busy = busy; e_rd = 0; e_wd = 0; e_tag = 0;
      e_chk_maddr = 1; e_maddr = 0; e_chk_cdata = 1; e_cdata = 0; e_caddr = 0;
   endtask

   always @(posedge clk) begin
      #3;
      if (chk_en) begin
         chk("fsm_busy", 16'(fsm_busy), 16'(e_busy));
         chk("mem_read_en", 16'(mem_read_en), 16'(e_rd));
         if (e_chk_maddr) chk("memory_address", memory_address, e_maddr);
         chk("write_data_array", 16'(write_data_array), 16'(e_wd));
         if (e_chk_cdata) chk("cache_data", cache_data, e_cdata);
         chk("cache_address", cache_address, e_caddr);
         chk("write_tag_array", 16'(write_tag_array), 16'(e_tag));
         chk("fill_done", 16'(fill_done), 16'(e_tag));
      end
      if (write_data_array === 1'b1)
         mdata[{cache_address[10:4], cache_address[3:1]}] <= cache_data;
      if (write_tag_array === 1'b1) begin
         mtag[cache_address[10:4]]   <= cache_address[15:11];
         mvalid[cache_address[10:4]] <= 1'b1;
      end
   end

   // One fill: miss in cycle 0, requests 1..8, returns 1+L..8+L, TAG at 9+L.
   task automatic run_fill(input logic [15:0] addr, input int lat, input bit hold,
                           input bit extra, input int abort_at, input bit pin);
      logic [15:0] b;
      b = addr & 16'hFFF0;
      for (int k = 0; k <= 9 + lat; k++) begin
         @(posedge clk); #1;
         miss_detected     = (k == 0) || hold;
         miss_address      = (k == 0) ? addr : (hold ? 16'hFFFF : addr);
         memory_data_valid = (k >= 1 + lat && k <= 8 + lat) || (extra && k == 9 + lat);
         memory_data       = 16'h0;
         if (k >= 1 + lat && k <= 8 + lat) memory_data = word_of(b + 16'(2 * (k - 1 - lat)));
         else if (memory_data_valid) memory_data = 16'hDEAD;
         e_busy      = 1;
         e_rd        = (k >= 1 && k <= 8);
         e_chk_maddr = e_rd || (k == 0);
         e_maddr     = e_rd ? b + 16'(2 * (k - 1)) : 16'h0;
         e_wd        = (k >= 1 + lat && k <= 8 + lat);
         e_chk_cdata = e_wd || (k == 0);
         e_cdata     = e_wd ? word_of(b + 16'(2 * (k - 1 - lat))) : 16'h0;
         e_caddr     = (k == 0) ? 16'h0 : (e_wd ? b + 16'(2 * (k - 1 - lat)) : b);
         e_tag       = (k == 9 + lat);
         if (k == abort_at) begin
            rst = 1; exp_idle(0);
            @(posedge clk); #1;
            miss_detected = 0; memory_data_valid = 0; memory_data = 0;
            rst = 0;
            return;
         end
         if (pin) begin
            #3;
            case (k)
               5:  chk("pin caddr c5", cache_address, 16'h1A30);
               8:  chk("pin maddr c8", memory_address, 16'h1A3E);
               12: chk("pin cdata c12", cache_data, 16'h4F6B);
               13: chk("pin tag c13", 16'(write_tag_array), 16'h1);
               14: chk("pin busy c14", 16'(fsm_busy), 16'h0);
               default: ;
            endcase
         end
      end
   endtask

   task automatic idle_cycles(input int n, input bit vpulse);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         miss_detected = 0; miss_address = 16'h0;
         memory_data_valid = vpulse; memory_data = 16'h1234;
         exp_idle(0);
      end
   endtask

   task automatic verify_block(input logic [15:0] addr);
      logic [6:0] idx;
      idx = addr[10:4];
      chk("tag valid", 16'(mvalid[idx]), 16'h1);
      chk("tag value", 16'(mtag[idx]), 16'(addr[15:11]));
      for (int w = 0; w < 8; w++)
         chk("block word", mdata[{idx, 3'(w)}], word_of((addr & 16'hFFF0) + 16'(2 * w)));
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin mvalid[i] = 0; mtag[i] = 0; end
      for (int i = 0; i < 1024; i++) mdata[i] = 16'h0;
      rst = 1; miss_detected = 1; miss_address = 16'h1A36;
      memory_data_valid = 0; memory_data = 0;
      exp_idle(0);
      chk_en = 1;
      repeat (2) @(posedge clk);
      #1; rst = 0; miss_detected = 0;            // first cycle after release: all quiet
      idle_cycles(1, 0);

      run_fill(16'h1A36, 4, 0, 0, -1, 1);        // basic fill, literal pins
      idle_cycles(1, 0);
      verify_block(16'h1A36);

      run_fill(16'h2468, 1, 0, 0, -1, 0);        // latency sweep
      idle_cycles(1, 0);
      run_fill(16'hBEEE, 7, 0, 0, -1, 0);
      idle_cycles(1, 0);
      verify_block(16'h2468);
      verify_block(16'hBEEE);

      idle_cycles(3, 1);                          // stray returns in IDLE
      run_fill(16'h3336, 3, 1, 1, -1, 0);         // miss held + extra valid in TAG
      idle_cycles(2, 1);
      verify_block(16'h3336);

      run_fill(16'h0040, 4, 0, 0, 6, 0);          // reset mid-fill
      run_fill(16'hF7F0, 2, 0, 0, -1, 0);
      idle_cycles(1, 0);
      chk("no tag after abort", 16'(mvalid[7'h04]), 16'h0);
      verify_block(16'hF7F0);

      run_fill(16'h0010, 3, 0, 0, -1, 0);         // back-to-back, same index
      run_fill(16'h8010, 3, 0, 0, -1, 0);
      idle_cycles(2, 0);
      verify_block(16'h8010);
      chk("reread 0x801E hit", 16'(mvalid[7'h01] && mtag[7'h01] == 5'h10), 16'h1);
      chk("reread 0x801E data", mdata[{7'h01, 3'd7}], 16'hD54B);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
